// File: rtl/tls_pkg.sv
// tls_pkg: shared state encoding and default sizing for the multi-phase traffic-light sequencer
package tls_pkg;
   typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;
   localparam int NPH_DEF = 2;
   localparam int CW_DEF = 4;
endpackage

// File: rtl/tls_next_phase.sv
// tls_next_phase: finds the next enabled phase after p, wrapping modulo NPH; returns p when it is the only one
module tls_next_phase import tls_pkg::*; #(
   parameter int NPH = NPH_DEF,
   parameter int PW = (NPH > 1) ? $clog2(NPH) : 1
)(
   input  logic [NPH-1:0] en,
   input  logic [PW-1:0]  p,
   output logic [PW-1:0]  nxt
);
   // scanning from the farthest offset down lets the nearest enabled phase win
   always_comb begin
      nxt = p;
      for (int i = NPH - 1; i >= 1; i--)
         if (en[(int'(p) + i) % NPH]) nxt = PW'((int'(p) + i) % NPH);
   end
endmodule

// File: rtl/tls_multi.sv
// tls_multi: NPH-phase traffic-light sequencer with latched per-phase green/yellow and shared all-red timing
module tls_multi import tls_pkg::*; #(
   parameter int NPH = NPH_DEF,
   parameter int CW = CW_DEF,
   localparam int PW = (NPH > 1) ? $clog2(NPH) : 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              set,
   input  logic              stop,
   input  logic              jump,
   input  logic [NPH*CW-1:0] g_dur,
   input  logic [NPH*CW-1:0] y_dur,
   input  logic [CW-1:0]     ar_dur,
   output logic [NPH-1:0]    gout,
   output logic [NPH-1:0]    yout,
   output logic [NPH-1:0]    rout,
   output logic [PW-1:0]     phase
);
   state_t st, ns;
   logic [PW-1:0] p, pn, np, lo;
   logic [CW-1:0] cnt, cn, dur, gp, yp, arl;
   logic [NPH*CW-1:0] gl, yl;
   logic [NPH-1:0] en, gen, gn, yn;
   logic last;

   for (genvar k = 0; k < NPH; k++) begin : g_en
      assign en[k] = |gl[k*CW +: CW];
      assign gen[k] = |g_dur[k*CW +: CW];
   end

   tls_next_phase #(.NPH(NPH), .PW(PW)) u_next (.en(en), .p(p), .nxt(np));
   // lowest enabled phase of the incoming config: search starting after the top index
   tls_next_phase #(.NPH(NPH), .PW(PW)) u_low (.en(gen), .p(PW'(NPH - 1)), .nxt(lo));

   assign gp = gl[int'(p)*CW +: CW];
   assign yp = yl[int'(p)*CW +: CW];
   assign dur = st == GREEN ? gp : st == YELLOW ? yp : arl;
   assign last = cnt == dur - 1'b1;

   always_comb begin
      ns = st;
      pn = p;
      cn = cnt + 1'b1;
      if (set) begin
         ns = |g_dur ? GREEN : IDLE;
         pn = |g_dur ? lo : '0;
         cn = '0;
      end else if (jump && st != IDLE) begin
         cn = '0;
         ns = (st != ALLRED && arl == '0) ? GREEN : ALLRED;
         pn = ns == GREEN ? np : p;
      end else if (stop || st == IDLE) begin
         cn = cnt;
      end else if (last) begin
         cn = '0;
         ns = st == GREEN  ? (yp != '0 ? YELLOW : arl != '0 ? ALLRED : GREEN) :
              st == YELLOW ? (arl != '0 ? ALLRED : GREEN) : GREEN;
         pn = ns == GREEN ? np : p;
      end
      gn = ns == GREEN ? NPH'(1) << pn : '0;
      yn = ns == YELLOW ? NPH'(1) << pn : '0;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st <= IDLE;
         p <= '0;
         cnt <= '0;
         gl <= '0;
         yl <= '0;
         arl <= '0;
         gout <= '0;
         yout <= '0;
         rout <= '0;
      end else begin
         st <= ns;
         p <= pn;
         cnt <= cn;
         if (set) begin
            gl <= g_dur;
            yl <= y_dur;
            arl <= ar_dur;
         end
         gout <= gn;
         yout <= yn;
         rout <= ns == IDLE ? '0 : ~(gn | yn);
      end

   assign phase = p;
endmodule

// File: doc/tls_multi.md
TLS_MULTI -- requirements
Module: tls_multi

Interface
REQ-001 The block SHALL have parameter NPH, default 2, meaning the number of signal phases (2..8).
REQ-002 The block SHALL have parameter CW, default 4, meaning the duration field width in bits.
REQ-003 The block SHALL have port clk, input, 1, the clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 The block SHALL have port set, input, 1, which loads the configuration and restarts the sequence.
REQ-006 The block SHALL have port stop, input, 1, which freezes state and counter.
REQ-007 The block SHALL have port jump, input, 1, which forces all-red clearance.
REQ-008 The block SHALL have port g_dur, input, NPH*CW, the per-phase green duration (phase k at bits [k*CW +: CW]).
REQ-009 The block SHALL have port y_dur, input, NPH*CW, the per-phase yellow duration.
REQ-010 The block SHALL have port ar_dur, input, CW, the all-red clearance duration.
REQ-011 The block SHALL have ports gout, yout and rout, output, NPH each, one lamp per phase.
REQ-012 The block SHALL have port phase, output, clog2(NPH) (minimum 1), the current phase index.

Function
REQ-013 States SHALL be IDLE, GREEN, YELLOW and ALLRED, with a phase register p and a CW-bit counter cnt.
REQ-014 Priority each cycle SHALL be set > jump > stop > normal sequencing.
REQ-015 set=1 SHALL latch g_dur, y_dur and ar_dur on that clock edge; configuration SHALL be held otherwise. Latching occurs on the clock edge only, never on any set edge.
REQ-016 A phase SHALL be enabled when its latched g_dur is nonzero.
REQ-017 On set: the next state SHALL be GREEN of the lowest enabled phase with cnt=0. If no phase is enabled, the next state SHALL be IDLE.
REQ-018 Each state SHALL be entered with cnt=0 and SHALL exit on the cycle where cnt==dur-1. Otherwise cnt SHALL increment, so a state lasts exactly dur cycles.
REQ-019 GREEN exit SHALL go to YELLOW, or to ALLRED if y_dur[p]==0, or to next-phase GREEN if that duration is also 0.
REQ-020 YELLOW exit SHALL go to ALLRED, or to next-phase GREEN if ar_dur==0.
REQ-021 ALLRED exit SHALL go to GREEN of the next enabled phase, searching p+1, p+2, ... modulo NPH. If p is the only enabled phase, the next phase SHALL be p itself.
REQ-022 jump in GREEN or YELLOW SHALL enter ALLRED with cnt=0 (or next-phase GREEN if ar_dur==0). In ALLRED it SHALL restart cnt=0. In IDLE it SHALL be ignored.
REQ-023 stop SHALL hold state, p and cnt unchanged. Lamps SHALL be unchanged. stop in IDLE SHALL keep IDLE.
REQ-024 Lamps SHALL be decoded from registered state only, with no input-to-output combinational path.
REQ-025 In GREEN, gout[p]=1; in YELLOW, yout[p]=1.
REQ-026 In GREEN, YELLOW and ALLRED, rout SHALL be 1 for every phase not lit green or yellow.
REQ-027 In IDLE, all lamps SHALL be 0.
REQ-028 The block SHALL never light more than one lamp per phase, and never green or yellow on two phases at once.
REQ-029 phase SHALL equal p. It SHALL be 0 in IDLE.
REQ-030 cnt SHALL never wrap: the maximum duration is 2^CW-1 cycles.

Reset
REQ-031 reset SHALL asynchronously force IDLE, p=0, cnt=0 and all latched durations to 0.
REQ-032 During reset, all lamps SHALL be 0 and phase=0.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence. After release, the block SHALL stay IDLE until set.

Structure
REQ-034 State encodings and the default NPH/CW SHALL reside in the shared package tls_pkg.
REQ-035 The next-enabled-phase search SHALL be a sub-module tls_next_phase with inputs an enable mask and the current p, and output the next index; it SHALL be purely combinational.
REQ-036 Implementation size SHALL be within 120-400 lines.

Verification (NPH=2, CW=4 unless stated)
REQ-037 set with g={3,2}, y={1,1}, ar=1 -> phase0 G for 3 cycles, Y 1, AR 1, then phase1 G 2, Y 1, AR 1, then phase0 G; rout[1]=1 throughout phase0.
REQ-038 Same config, stop high for 4 cycles during phase0 G at cnt=1 -> gout[0] held 4 cycles longer, then 2 more G cycles.
REQ-039 jump during phase1 G at cnt=0 -> next cycle ALLRED for 1 cycle, then phase0 G; set and jump together -> phase0 G.
REQ-040 g={0,3}, y={0,2}, ar=0 -> phase1 only: G 3 cycles, Y 2, directly G again; gout[0]/yout[0] never 1, rout[0]=1 throughout.
REQ-041 NPH=4, g={1,0,2,0}, y={1,1,1,1}, ar=2 -> phase order 0,2,0. All-zero g -> remains IDLE with all lamps 0.
REQ-042 reset asserted asynchronously mid-YELLOW -> lamps 0 immediately; after release, IDLE until set; durations read back as 0 (set with g all 0 keeps IDLE).
